alu_share_ctrl: RTL

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_pkg.sv | 22 ++
 rtl/alu_share_if.sv | 54 +++++
 rtl/alu_share_rr_arbiter2.sv | 43 ++++
 rtl/alu_share_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared types for the two-requester ALU sharing controller.
// Holds the controller state enum and the in_signal opcode constants.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_ANDI = 4'b1100;
    localparam logic [3:0] OP_LD   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1111;
    localparam logic [3:0] OP_ORI  = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1011;

endpackage

// File: rtl/alu_share_if.sv
// alu_share_if: bundle of requester, ALU and response signals.
// slave = controller side, master = requesters/ALU/response consumer side.
interface alu_share_if #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_in_signal;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_cout;
    logic             alu_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_cout;
    logic             rsp_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero, alu_cout, alu_ovf,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_in_signal,
        output rsp_valid, rsp_id, rsp_result,
        output rsp_zero, rsp_cout, rsp_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, alu_cout, alu_ovf,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_in_signal,
        input  rsp_valid, rsp_id, rsp_result,
        input  rsp_zero, rsp_cout, rsp_ovf
    );

endinterface

// File: rtl/alu_share_rr_arbiter2.sv
// rr_arbiter2: 2-way grant with a pointer (ptr=0 favours requester 0).
// Ports: clk, rst, en_i (grant allowed), req_i[1:0], gnt_o[1:0] one-hot.
// ALU_SHARE_RR_EN defined: pointer flips to the non-winner on each grant;
// otherwise the pointer is pinned to 0, giving fixed priority to requester 0.
module rr_arbiter2
    import alu_share_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_q);
            gnt_o[1] = req_i[1] & (~req_i[0] |  ptr_q);
        end
`ifdef ALU_SHARE_RR_EN
        // winner 0 -> point at 1, winner 1 -> point at 0
        if (|gnt_o) begin
            ptr_d = gnt_o[0];
        end
`else
        ptr_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between two requesters, IDLE->EXEC->RESP.
// Ports: clk, rst (sync, active-high), bus (alu_share_if.slave). ALU_SHARE_RR_EN selects round-robin.
module alu_share_ctrl #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_share_if.slave  bus
);
    import alu_share_pkg::*;

    state_e           state_q, state_d;
    logic [1:0]       gnt;
    logic             arb_en;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // no grant while reset is held, so the first grant follows its release
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (arb_en),
        .req_i ({bus.req1_valid, bus.req0_valid}),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rsp_id_d = rsp_id_q;
        res_d    = res_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (gnt[1]) begin
                    alu_a_d  = bus.req1_a;
                    alu_b_d  = bus.req1_b;
                    alu_op_d = bus.req1_op;
                    rsp_id_d = 1'b1;
                    state_d  = EXEC;
                end else if (gnt[0]) begin
                    alu_a_d  = bus.req0_a;
                    alu_b_d  = bus.req0_b;
                    alu_op_d = bus.req0_op;
                    rsp_id_d = 1'b0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_d   = bus.alu_result;
                zero_d  = bus.alu_zero;
                cout_d  = bus.alu_cout;
                ovf_d   = bus.alu_ovf;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rsp_id_q <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            rsp_id_q <= rsp_id_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.req0_ready    = gnt[0];
    assign bus.req1_ready    = gnt[1];
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_in_signal = alu_op_q;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = res_q;
    assign bus.rsp_zero      = zero_q;
    assign bus.rsp_cout      = cout_q;
    assign bus.rsp_ovf       = ovf_q;

endmodule
